// File: rtl/serial_checking_sink_pkg.sv
// serial_checking_sink_pkg: shared constants, FSM encoding and LFSR step for the checking sink.
package serial_checking_sink_pkg;
   localparam int FLIT_W_DEF = 8;
   localparam int ADDR_SZ_DEF = 4;
   localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
   // x^8+x^6+x^5+x^4+1 expressed as a mask over the shift-left register bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   typedef enum logic [1:0] {IDLE, RECV, CHECK, STALL} state_t;
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/serial_checking_sink_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, advances every cycle outside reset.
module lfsr8
   import serial_checking_sink_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] state
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= SEED;
      else state <= lfsr_next(state);
endmodule

// File: rtl/serial_checking_sink.sv
// serial_checking_sink: deserializes router tx frames, checks destination, counts flits and
// applies LFSR-driven back-pressure.
module serial_checking_sink
   import serial_checking_sink_pkg::*;
#(
   parameter int         id          = 0,
   parameter int         hospitality = 255,
   parameter int         FLIT_W      = FLIT_W_DEF,
   parameter int         ADDR_SZ     = ADDR_SZ_DEF,
   parameter logic [7:0] LFSR_SEED   = LFSR_SEED_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   output logic              channel_busy,
   output logic [FLIT_W-1:0] flit_out,
   output logic              flit_valid,
   output logic              misroute,
   output logic [19:0]       rx_count,
   output logic [15:0]       err_count
);
   localparam int CW = $clog2(FLIT_W);
   state_t            state;
   logic [CW-1:0]     bitcnt;
   logic [FLIT_W-1:0] shreg;
   logic [4:0]        stall_cnt;
   logic [7:0]        lfsr;
   logic              miss;
   logic              stall_go;
   lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .state(lfsr));
   assign miss = shreg[FLIT_W-1 -: ADDR_SZ] != ADDR_SZ'(id);
   assign stall_go = int'(lfsr) > hospitality;
   // channel_busy is registered alongside the state so it is high exactly when state != IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         bitcnt       <= '0;
         shreg        <= '0;
         stall_cnt    <= '0;
         channel_busy <= 1'b0;
         flit_out     <= '0;
         flit_valid   <= 1'b0;
         misroute     <= 1'b0;
         rx_count     <= '0;
         err_count    <= '0;
      end else begin
         flit_valid <= 1'b0;
         misroute   <= 1'b0;
         case (state)
            IDLE: if (serial_in) begin
               state        <= RECV;
               bitcnt       <= '0;
               channel_busy <= 1'b1;
            end
            RECV: begin
               shreg[bitcnt] <= serial_in;
               bitcnt        <= bitcnt + 1'b1;
               if (bitcnt == CW'(FLIT_W - 1)) state <= CHECK;
            end
            CHECK: begin
               flit_valid <= 1'b1;
               flit_out   <= shreg;
               misroute   <= miss;
               if (rx_count != '1) rx_count <= rx_count + 1'b1;
               if (miss && err_count != '1) err_count <= err_count + 1'b1;
               if (stall_go) begin
                  stall_cnt <= {1'b0, lfsr[3:0]} + 5'd1;
                  state     <= STALL;
               end else begin
                  state        <= IDLE;
                  channel_busy <= 1'b0;
               end
            end
            STALL: if (stall_cnt == 5'd1) begin
               state        <= IDLE;
               channel_busy <= 1'b0;
            end else stall_cnt <= stall_cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
